alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `Alu` instance (integer and FPU operations) between `N` requesters. It latches a granted requester's command and operands, drives the ALU `state` through `ALU_BEGIN` → `ALU_RESULTS`, and waits for the ALU `next_state` handshake. It returns `dst`/`dst_h` to the owner with a one-hot `done` pulse, and aborts with `err` if the ALU never answers (e.g. unsupported `cmd_code`). It sits between the instruction-execution units and the single ALU.

---
 rtl/alu_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter and sequencer sharing one ALU between N requesters
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   clk_oe                phase enable shared with the ALU; state advances only on edges where it is 0
//   req                   per-requester level request, held until the matching done
//   cmd, src0, src1       packed per-requester command (32 bits each) and operands (DATA_W each)
//   grant                 one-hot current owner, all-zero when idle
//   done, err             one-hot completion strobe; err=1 marks a timeout abort
//   res_dst, res_dst_h    result low/high words, valid with done, held until the next completion
//   alu_command           latched command driven to the ALU
//   alu_src0, alu_src1    latched operands driven to the ALU
//   alu_state             ALU_BEGIN, ALU_RESULTS or IDLE_CODE
//   alu_next_state        ALU completion flag
//   alu_dst, alu_dst_h    ALU result words
module alu_arbiter #(
  parameter int N = 4,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 64,
  parameter int STATE_SIZE = 4,
  parameter logic [STATE_SIZE-1:0] IDLE_CODE = STATE_SIZE'(0),
  parameter logic [STATE_SIZE-1:0] ALU_BEGIN = STATE_SIZE'(1),
  parameter logic [STATE_SIZE-1:0] ALU_RESULTS = STATE_SIZE'(2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_oe,
  input  logic [N-1:0]          req,
  input  logic [N*32-1:0]       cmd,
  input  logic [N*DATA_W-1:0]   src0,
  input  logic [N*DATA_W-1:0]   src1,
  output logic [N-1:0]          grant,
  output logic [N-1:0]          done,
  output logic                  err,
  output logic [DATA_W-1:0]     res_dst,
  output logic [DATA_W-1:0]     res_dst_h,
  output logic [31:0]           alu_command,
  output logic [DATA_W-1:0]     alu_src0,
  output logic [DATA_W-1:0]     alu_src1,
  output logic [STATE_SIZE-1:0] alu_state,
  input  logic                  alu_next_state,
  input  logic [DATA_W-1:0]     alu_dst,
  input  logic [DATA_W-1:0]     alu_dst_h
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_COLLECT
  } state_t;

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    ptr, ptr_nxt;
  logic [PTR_W-1:0]    owner, owner_nxt, owner_inc;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [N-1:0]        grant_nxt, done_nxt;
  logic                err_nxt;
  logic [DATA_W-1:0]   res_dst_nxt, res_dst_h_nxt;
  logic [31:0]         alu_command_nxt;
  logic [DATA_W-1:0]   alu_src0_nxt, alu_src1_nxt;
  logic                found;
  int                  sel;

  // First set request at or after ptr, wrapping N-1 -> 0.
  always_comb begin
    found = 1'b0;
    sel   = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        sel   = (int'(ptr) + i) % N;
      end
    end
  end

  assign owner_inc = (owner == PTR_W'(N - 1)) ? '0 : owner + 1'b1;

  // Next-state values assume an enabled edge; the register block only
  // loads them when clk_oe is low. done/err default to 0 so each strobe
  // lasts exactly one enabled period.
  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    owner_nxt       = owner;
    cnt_nxt         = cnt;
    grant_nxt       = grant;
    done_nxt        = '0;
    err_nxt         = 1'b0;
    res_dst_nxt     = res_dst;
    res_dst_h_nxt   = res_dst_h;
    alu_command_nxt = alu_command;
    alu_src0_nxt    = alu_src0;
    alu_src1_nxt    = alu_src1;

    unique case (state)
      S_IDLE: begin
        grant_nxt = '0;
        if (found) begin
          alu_command_nxt = cmd[32*sel +: 32];
          alu_src0_nxt    = src0[DATA_W*sel +: DATA_W];
          alu_src1_nxt    = src1[DATA_W*sel +: DATA_W];
          grant_nxt[sel]  = 1'b1;
          owner_nxt       = PTR_W'(sel);
          cnt_nxt         = '0;
          state_nxt       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (alu_next_state) begin
          state_nxt = S_COLLECT;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          // This edge would bring the counter to TIMEOUT: give up.
          done_nxt[owner] = 1'b1;
          err_nxt         = 1'b1;
          res_dst_nxt     = '0;
          res_dst_h_nxt   = '0;
          ptr_nxt         = owner_inc;
          grant_nxt       = '0;
          state_nxt       = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_COLLECT: begin
        res_dst_nxt     = alu_dst;
        res_dst_h_nxt   = alu_dst_h;
        done_nxt[owner] = 1'b1;
        ptr_nxt         = owner_inc;
        grant_nxt       = '0;
        state_nxt       = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      owner       <= '0;
      cnt         <= '0;
      grant       <= '0;
      done        <= '0;
      err         <= 1'b0;
      res_dst     <= '0;
      res_dst_h   <= '0;
      alu_command <= '0;
      alu_src0    <= '0;
      alu_src1    <= '0;
    end else if (!clk_oe) begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      owner       <= owner_nxt;
      cnt         <= cnt_nxt;
      grant       <= grant_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
      res_dst     <= res_dst_nxt;
      res_dst_h   <= res_dst_h_nxt;
      alu_command <= alu_command_nxt;
      alu_src0    <= alu_src0_nxt;
      alu_src1    <= alu_src1_nxt;
    end
  end

  always_comb begin
    alu_state = IDLE_CODE;
    case (state)
      S_ISSUE:   alu_state = ALU_BEGIN;
      S_COLLECT: alu_state = ALU_RESULTS;
      default:   alu_state = IDLE_CODE;
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU and round-robin model
module tb_alu_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int SS = 4;
  localparam logic [SS-1:0] IDLE_C  = 4'd0;
  localparam logic [SS-1:0] BEGIN_C = 4'd1;
  localparam logic [SS-1:0] RES_C   = 4'd2;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MOV  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_SLOW = 4'd8;
  localparam logic [3:0] OP_BAD  = 4'd15;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            clk_oe = 1'b0;
  logic            oe_hold = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*32-1:0] cmd = '0;
  logic [N*DW-1:0] src0 = '0;
  logic [N*DW-1:0] src1 = '0;
  logic [N-1:0]    grant, done;
  logic            err;
  logic [DW-1:0]   res_dst, res_dst_h;
  logic [31:0]     alu_command;
  logic [DW-1:0]   alu_src0, alu_src1;
  logic [SS-1:0]   alu_state;
  logic            alu_next_state = 1'b0;
  logic [DW-1:0]   alu_dst = '0;
  logic [DW-1:0]   alu_dst_h = '0;

  alu_arbiter #(
    .N(N), .DATA_W(DW), .TIMEOUT(TO), .STATE_SIZE(SS),
    .IDLE_CODE(IDLE_C), .ALU_BEGIN(BEGIN_C), .ALU_RESULTS(RES_C)
  ) dut (
    .clk(clk), .rst(rst), .clk_oe(clk_oe),
    .req(req), .cmd(cmd), .src0(src0), .src1(src1),
    .grant(grant), .done(done), .err(err),
    .res_dst(res_dst), .res_dst_h(res_dst_h),
    .alu_command(alu_command), .alu_src0(alu_src0), .alu_src1(alu_src1),
    .alu_state(alu_state), .alu_next_state(alu_next_state),
    .alu_dst(alu_dst), .alu_dst_h(alu_dst_h)
  );

  typedef struct {
    int            owner;
    logic          err;
    logic [DW-1:0] dst;
    logic [DW-1:0] dsth;
    int            clocks;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mptr = 0;

  logic [3:0]    b_op[N];
  logic [DW-1:0] b_a[N];
  logic [DW-1:0] b_b[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Result as {dst_h, dst}.
  function automatic logic [2*DW-1:0] op_eval(input logic [3:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    logic [2*DW-1:0] wa, wb;
    wa = {{DW{1'b0}}, a};
    wb = {{DW{1'b0}}, b};
    case (op)
      OP_ADD:  return {{DW{1'b0}}, a + b};
      OP_SUB:  return {{DW{1'b0}}, a - b};
      OP_MOV:  return {{DW{1'b0}}, a};
      OP_MUL:  return wa * wb;
      OP_DIV:  return (b == 0) ? {a, {DW{1'b1}}} : {a % b, a / b};
      OP_SLOW: return {a ^ b, a + b + 1'b1};
      default: return '0;
    endcase
  endfunction

  // Active ALU edges needed to answer; 0 = never answers.
  function automatic int alu_lat(input logic [3:0] op);
    if (op == OP_BAD) return 0;
    if (op == OP_SLOW) return 3;
    return 1;
  endfunction

  // Clocks from the grant edge to the done edge with clk_oe toggling.
  function automatic int exp_clocks(input logic [3:0] op);
    if (op == OP_BAD) return 2 * TO;
    return 2 * alu_lat(op) + 2;
  endfunction

  // Behavioural ALU, evaluated after each active (clk_oe==1) edge.
  logic alu_busy = 1'b0;
  int   alu_cnt = 0;

  task automatic alu_step();
    logic [2*DW-1:0] r;
    if (!rst || alu_state != BEGIN_C) begin
      alu_busy       = 1'b0;
      alu_next_state = 1'b0;
    end else begin
      if (!alu_busy) begin
        alu_busy  = 1'b1;
        alu_cnt   = alu_lat(alu_command[31:28]);
        alu_dst   = $urandom;
        alu_dst_h = $urandom;
      end
      if (alu_cnt > 0) begin
        alu_cnt--;
        if (alu_cnt == 0) begin
          r = op_eval(alu_command[31:28], alu_src0, alu_src1);
          alu_dst        = r[DW-1:0];
          alu_dst_h      = r[2*DW-1:DW];
          alu_next_state = 1'b1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      #5 clk = 1'b1;
      cyc++;
      #5 clk = 1'b0;
      if (clk_oe) alu_step();
      if (!oe_hold) clk_oe = ~clk_oe;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Monitor: pops the scoreboard on every rising done.
  logic [N-1:0] m_pdone = '0;
  logic [N-1:0] m_pgrant = '0;
  logic [N-1:0] m_gown = '0;
  logic [N-1:0] m_onehot;
  int           m_gcyc = 0;
  int           m_width = 0;
  exp_t         m_e;

  initial begin
    forever begin
      @(negedge clk);
      if (grant != 0 && m_pgrant == 0) begin
        m_gcyc = cyc;
        m_gown = grant;
      end
      if (done != 0 && m_pdone == 0) begin
        m_width = 0;
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          m_e = sb.pop_front();
          m_onehot = '0;
          m_onehot[m_e.owner] = 1'b1;
          check("done_owner", done, m_onehot);
          check("done_err", err, m_e.err);
          check("res_dst", res_dst, m_e.dst);
          check("res_dst_h", res_dst_h, m_e.dsth);
          check("latency", cyc - m_gcyc, m_e.clocks);
          check("grant_vs_done", m_gown, done);
        end
      end
      if (done != 0) m_width++;
      if (done == 0 && m_pdone != 0) check("done_width", m_width, 2);
      m_pdone  = done;
      m_pgrant = grant;
    end
  end

  // Round-robin reference: all requests in mask are raised together and held.
  task automatic push_model(input logic [N-1:0] mask);
    int j, last;
    exp_t e;
    logic [2*DW-1:0] r;
    last = -1;
    for (int i = 0; i < N; i++) begin
      j = (mptr + i) % N;
      if (mask[j]) begin
        e.owner  = j;
        e.err    = (b_op[j] == OP_BAD);
        r        = e.err ? '0 : op_eval(b_op[j], b_a[j], b_b[j]);
        e.dst    = r[DW-1:0];
        e.dsth   = r[2*DW-1:DW];
        e.clocks = exp_clocks(b_op[j]);
        sb.push_back(e);
        last = j;
      end
    end
    if (last >= 0) mptr = (last + 1) % N;
  endtask

  task automatic drive(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        cmd[32*i +: 32]  = {b_op[i], 28'($urandom)};
        src0[DW*i +: DW] = b_a[i];
        src1[DW*i +: DW] = b_b[i];
      end
    end
    req = req | mask;
  endtask

  // Drops each req on its done and scrambles the owner's inputs after grant.
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (req != 0 && n < budget) begin
      @(negedge clk);
      n++;
      req = req & ~done;
      for (int i = 0; i < N; i++) begin
        if (grant[i]) begin
          src0[DW*i +: DW] = $urandom;
          src1[DW*i +: DW] = $urandom;
        end
      end
    end
    check("batch_drained", req, 0);
    req = '0;
  endtask

  task automatic run_batch(input logic [N-1:0] mask);
    @(negedge clk);
    drive(mask);
    push_model(mask);
    wait_idle(400);
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (grant == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [N-1:0] mask;
    int r;
    for (int i = 0; i < N; i++) begin
      b_op[i] = OP_ADD;
      b_a[i]  = '0;
      b_b[i]  = '0;
    end

    repeat (3) @(negedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_res_dst", res_dst, 0);
    check("rst_res_dst_h", res_dst_h, 0);
    check("rst_alu_command", alu_command, 0);
    check("rst_alu_src0", alu_src0, 0);
    check("rst_alu_src1", alu_src1, 0);
    check("rst_alu_state", alu_state, IDLE_C);
    @(negedge clk);
    rst = 1'b1;

    // Single add with ALU state sequence.
    b_op[0] = OP_ADD; b_a[0] = 5; b_b[0] = 7;
    @(negedge clk);
    drive(4'b0001);
    push_model(4'b0001);
    wait_grant();
    check("add_grant", grant, 4'b0001);
    check("add_state_begin", alu_state, BEGIN_C);
    check("add_cmd_op", alu_command[31:28], OP_ADD);
    check("add_src0", alu_src0, 5);
    check("add_src1", alu_src1, 7);
    @(negedge clk);
    @(negedge clk);
    check("add_state_results", alu_state, RES_C);
    wait_idle(100);

    // All four requesting moves.
    for (int i = 0; i < N; i++) begin
      b_op[i] = OP_MOV; b_a[i] = $urandom; b_b[i] = $urandom;
    end
    run_batch(4'b1111);

    // Pointer priority: after 2, requests 1 and 3 together serve 3 first.
    b_op[2] = OP_ADD; b_op[1] = OP_SUB; b_op[3] = OP_ADD;
    run_batch(4'b0100);
    run_batch(4'b1010);

    // Divide with operands scrambled after the grant.
    b_op[0] = OP_DIV; b_a[0] = 100; b_b[0] = 7;
    run_batch(4'b0001);

    // Unsupported command runs into the timeout.
    b_op[1] = OP_BAD; b_a[1] = $urandom; b_b[1] = $urandom;
    run_batch(4'b0010);
    #1;
    check("timeout_state_idle", alu_state, IDLE_C);

    // clk_oe held high: nothing advances.
    @(negedge clk);
    #1;
    if (!clk_oe) begin
      @(negedge clk);
      #1;
    end
    oe_hold = 1'b1;
    b_op[3] = OP_ADD; b_a[3] = $urandom; b_b[3] = $urandom;
    drive(4'b1000);
    push_model(4'b1000);
    repeat (6) begin
      @(negedge clk);
      check("hold_grant", grant, 0);
    end
    check("hold_state", alu_state, IDLE_C);
    oe_hold = 1'b0;
    wait_idle(100);

    // Asynchronous reset while in ISSUE; requester re-served afterwards.
    b_op[2] = OP_ADD; b_a[2] = $urandom; b_b[2] = $urandom;
    @(negedge clk);
    drive(4'b0100);
    wait_grant();
    check("rst_mid_pre_grant", grant, 4'b0100);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_grant", grant, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_state", alu_state, IDLE_C);
    check("rst_mid_cmd", alu_command, 0);
    check("rst_mid_src0", alu_src0, 0);
    check("rst_mid_res_dst", res_dst, 0);
    check("rst_mid_res_dst_h", res_dst_h, 0);
    repeat (2) @(negedge clk);
    mptr = 0;
    push_model(4'b0100);
    rst = 1'b1;
    wait_idle(100);

    // Random batches.
    for (int k = 0; k < 40; k++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 19);
        if (r == 0)      b_op[i] = OP_BAD;
        else if (r < 4)  b_op[i] = OP_SLOW;
        else if (r < 7)  b_op[i] = OP_ADD;
        else if (r < 10) b_op[i] = OP_SUB;
        else if (r < 13) b_op[i] = OP_MOV;
        else if (r < 16) b_op[i] = OP_MUL;
        else             b_op[i] = OP_DIV;
        b_a[i] = $urandom;
        b_b[i] = (r >= 16) ? DW'($urandom_range(1, 1000)) : DW'($urandom);
      end
      run_batch(mask);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
